risc_run_ctrl: RTL and testbench
================================

# risc_run_ctrl

Run controller for `risc_processor`. It holds the core in reset, releases it, and lets it run until a halt or a cycle budget expires. It then takes ownership of the data-memory read port and streams the first `DUMP_WORDS` words out over a valid/ready interface. This replaces manual bench sequencing (fixed delay, then poking `inaddress`) with a deterministic hardware sequence for on-board and regression runs.

## Interface
- `DMEM_AW`, 10: data-memory address width (matches `inaddress`).
- `DMEM_DW`, 16: data-memory read width (matches `outdata`).
- `RST_CYCLES`, 4: cycles `cpu_reset` is held after `start`; legal range ≥1.
- `MAX_CYCLES`, 520: run budget in cycles; legal range ≥1.
- `DRAIN_CYCLES`, 3: cycles waited after halt for in-flight stores to retire.
- `DUMP_WORDS`, 3: number of words dumped, starting at address 0; legal range 1..2^DMEM_AW.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; sampled only in IDLE or DONE.
- `cpu_reset` out 1: drives the processor `reset`.
- `cpu_en` out 1: processor clock-enable / run.
- `halt_seen` in 1: processor decoded a halt instruction; level or pulse.
- `dmem_sel` out 1: 1 = controller owns the dmem read address mux.
- `dmem_addr` out DMEM_AW: read address, drives `inaddress` when `dmem_sel` = 1.
- `dmem_rdata` in DMEM_DW: read data, valid one cycle after `dmem_addr`.
- `dump_valid` out 1: dump word available.
- `dump_ready` in 1: consumer accepts the word.
- `dump_addr` out DMEM_AW: address of the current dump word.
- `dump_data` out DMEM_DW: the current dump word.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE.
- `timeout` out 1: sticky; set if the budget expired without a halt. Cleared by `start` or `reset`.

## Operation
- States: IDLE, RST, RUN, DRAIN, RD, CAP, OUT, DONE.
- IDLE/DONE + `start` → RST. The rst counter loads `RST_CYCLES-1`, `timeout` clears, `done` drops.
- RST: `cpu_reset` = 1, `cpu_en` = 0. Counter reaches 0 → RUN. Cycle counter loads 0.
- RUN: `cpu_reset` = 0, `cpu_en` = 1, and the cycle counter increments each cycle.
  - `halt_seen` → DRAIN.
  - Counter = `MAX_CYCLES-1` without `halt_seen` → DRAIN with `timeout` set.
  - If both happen in the same cycle, halt wins and `timeout` stays 0.
- DRAIN: `cpu_en` = 1 for `DRAIN_CYCLES` cycles, then `cpu_en` = 0 → RD. Dump index clears. If `DRAIN_CYCLES` = 0, go straight to RD.
- RD: `dmem_sel` = 1, `dmem_addr` = index → CAP.
- CAP: capture `dmem_rdata` into the `dump_data` register → OUT.
- OUT: `dump_valid` = 1.
  - `dump_data` and `dump_addr` stay stable while valid and not ready.
  - On `dump_valid & dump_ready`: if index = `DUMP_WORDS-1` → DONE, otherwise index+1 → RD.
- DONE: `cpu_en` = 0, `cpu_reset` = 0, `dmem_sel` = 0, `done` = 1. The core state remains inspectable.
- `start` outside IDLE/DONE is ignored.
- `halt_seen` outside RUN is ignored.
- Counter widths:
  - cycle counter is $clog2(MAX_CYCLES+1) bits;
  - index is DMEM_AW+1 bits, so `DUMP_WORDS` = 2^DMEM_AW does not wrap before the compare.

## Timing
- Reset values: state = IDLE; `cpu_reset` = 1 (core held while idle); `cpu_en`, `dmem_sel`, `dump_valid`, `busy`, `done`, `timeout` = 0; `dmem_addr`, `dump_addr`, `dump_data` = 0.
- All outputs are registered, or decoded directly from the state register; there are no combinational paths from inputs to outputs.
- `start` at edge N: `busy` rises at N+1, and `cpu_reset` is high for cycles N+1..N+RST_CYCLES.
- Run length: exactly `MAX_CYCLES` cycles with `cpu_en` = 1 in RUN when no halt occurs.
- Per dump word: 3 cycles minimum (RD, CAP, OUT with ready already high). Each cycle `dump_ready` is held low adds one cycle.
- `reset` asserted mid-operation: immediate return to the reset values. The dump stream aborts, and no partial handshake completes.

## Structure
- Package `risc_run_pkg`: state enum `run_state_t` and default parameter constants.
- One natural sub-module, `run_cycle_counter`: loadable down/up counter with a terminal-count flag, shared by the RST, RUN and DRAIN phases.
- Top-level wrapper: `dmem_sel` muxes `dmem_addr` against the external `inaddress`.

## Test plan
- GCD program (GCD(48,18)), `dump_ready` tied high:
  - `halt_seen` before budget expires → stream (0,48), (1,18), (2,6);
  - `timeout` = 0 and `done` = 1.
- Program with no halt, `MAX_CYCLES` = 20 → exactly 20 cycles of `cpu_en` in RUN, `timeout` = 1, and all 3 words are still dumped.
- `halt_seen` on the same cycle the budget expires → `timeout` = 0.
- `dump_ready` low for 5 cycles on word 1 → `dump_data` and `dump_addr` stable throughout, and no word is skipped or duplicated.
- `reset` pulse during OUT of word 1 → all outputs return to reset values next edge. A new `start` then yields a full 3-word dump.
- `start` pulse during RUN → ignored (run length unchanged). `start` in DONE → new sequence begins and `timeout` clears.

Source files
------------

// File: rtl/risc_run_pkg.sv
// Shared types and default parameters for the risc_processor run controller.
package risc_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DRAIN,
    S_RD,
    S_CAP,
    S_OUT,
    S_DONE
  } run_state_t;

  localparam int DEF_DMEM_AW      = 10;
  localparam int DEF_DMEM_DW      = 16;
  localparam int DEF_RST_CYCLES   = 4;
  localparam int DEF_MAX_CYCLES   = 520;
  localparam int DEF_DRAIN_CYCLES = 3;
  localparam int DEF_DUMP_WORDS   = 3;

  // The shared phase counter must hold the largest value any phase loads.
  function automatic int cnt_width(input int a, input int b, input int c);
    int w;
    w = $clog2(a + 1);
    if ($clog2(b + 1) > w) w = $clog2(b + 1);
    if ($clog2(c + 1) > w) w = $clog2(c + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Loadable up/down counter with a zero flag, time-shared by the RST, RUN and
// DRAIN phases of the run controller.
module run_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en)
      count <= up ? count + W'(1) : count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/risc_run_ctrl.sv
// Run controller: holds the core in reset, runs it until halt or budget
// expiry, drains stores, then streams the first DUMP_WORDS dmem words out.
//
// state | meaning
// IDLE  | core held in reset, waiting for start
// RST   | core reset asserted for RST_CYCLES
// RUN   | core enabled, cycle budget counting up
// DRAIN | core enabled for DRAIN_CYCLES so in-flight stores retire
// RD    | controller drives dmem read address
// CAP   | read data captured into dump_data
// OUT   | dump word offered on valid/ready
// DONE  | core frozen and inspectable, dump complete
module risc_run_ctrl
  import risc_run_pkg::*;
#(
  parameter int DMEM_AW      = DEF_DMEM_AW,
  parameter int DMEM_DW      = DEF_DMEM_DW,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int DUMP_WORDS   = DEF_DUMP_WORDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               cpu_reset,
  output logic               cpu_en,
  input  logic               halt_seen,
  output logic               dmem_sel,
  output logic [DMEM_AW-1:0] dmem_addr,
  input  logic [DMEM_DW-1:0] dmem_rdata,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [DMEM_AW-1:0] dump_addr,
  output logic [DMEM_DW-1:0] dump_data,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int CW = cnt_width(MAX_CYCLES, RST_CYCLES, DRAIN_CYCLES);
  localparam logic [CW-1:0]    RST_LOAD   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    RUN_LAST   = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0]    DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
  // Index is one bit wider than the address so a full-memory dump compares cleanly.
  localparam logic [DMEM_AW:0] LAST_IDX   = (DMEM_AW + 1)'(DUMP_WORDS - 1);

  run_state_t        state, state_nxt;
  logic [DMEM_AW:0]  idx;
  logic              cnt_load, cnt_en, cnt_up, cnt_zero;
  logic [CW-1:0]     cnt_val, cnt;
  logic              idx_clr, idx_inc, cap, set_to, clr_to;

  run_cycle_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .up       (cnt_up),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      dump_addr <= '0;
      dump_data <= '0;
      timeout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (idx_clr)
        idx <= '0;
      else if (idx_inc)
        idx <= idx + 1'b1;
      if (cap) begin
        dump_data <= dmem_rdata;
        dump_addr <= idx[DMEM_AW-1:0];
      end
      if (clr_to)
        timeout <= 1'b0;
      else if (set_to)
        timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_en    = 1'b0;
    cnt_up    = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    cap       = 1'b0;
    set_to    = 1'b0;
    clr_to    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RST;
          cnt_load  = 1'b1;
          cnt_val   = RST_LOAD;
          clr_to    = 1'b1;
        end
      end
      S_RST: begin
        if (cnt_zero) begin
          state_nxt = S_RUN;
          cnt_load  = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_RUN: begin
        // Halt takes priority over budget expiry in the same cycle.
        if (halt_seen || cnt == RUN_LAST) begin
          set_to = !halt_seen;
          if (DRAIN_CYCLES == 0) begin
            state_nxt = S_RD;
            idx_clr   = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
            cnt_load  = 1'b1;
            cnt_val   = DRAIN_LOAD;
          end
        end else begin
          cnt_en = 1'b1;
          cnt_up = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_zero) begin
          state_nxt = S_RD;
          idx_clr   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_RD:  state_nxt = S_CAP;
      S_CAP: begin
        cap       = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = S_RD;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cpu_reset  = (state == S_IDLE) || (state == S_RST);
  assign cpu_en     = (state == S_RUN) || (state == S_DRAIN);
  assign dmem_sel   = (state == S_RD);
  assign dmem_addr  = dmem_sel ? idx[DMEM_AW-1:0] : '0;
  assign dump_valid = (state == S_OUT);
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Randomized self-checking bench for risc_run_ctrl against a sequence-level
// model of phase lengths, timeout and dumped words.
module tb_risc_run_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int RSTC  = 4;
  localparam int MAXC  = 20;
  localparam int DRAIN = 3;
  localparam int DUMP  = 3;

  logic          clk = 1'b0;
  logic          reset, start, halt_seen, dump_ready;
  logic          cpu_reset, cpu_en, dmem_sel, dump_valid, busy, done, timeout;
  logic [AW-1:0] dmem_addr, dump_addr;
  logic [DW-1:0] dmem_rdata, dump_data;
  logic [DW-1:0] mem [1 << AW];

  int n_checks = 0;
  int n_fail   = 0;

  risc_run_ctrl #(
    .DMEM_AW(AW), .DMEM_DW(DW), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
    .DRAIN_CYCLES(DRAIN), .DUMP_WORDS(DUMP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_reset(cpu_reset),
    .cpu_en(cpu_en), .halt_seen(halt_seen), .dmem_sel(dmem_sel),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; data is garbage unless the controller owns the port.
  always @(posedge clk)
    dmem_rdata <= dmem_sel ? mem[dmem_addr] : DW'($urandom);

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cpu_reset"}, cpu_reset, 1);
    check({pfx, "_cpu_en"}, cpu_en, 0);
    check({pfx, "_dmem_sel"}, dmem_sel, 0);
    check({pfx, "_dump_valid"}, dump_valid, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_timeout"}, timeout, 0);
    check({pfx, "_dmem_addr"}, dmem_addr, 0);
    check({pfx, "_dump_addr"}, dump_addr, 0);
    check({pfx, "_dump_data"}, dump_data, 0);
  endtask

  // halt_at: RUN cycle index on which halt_seen is raised, -1 for none.
  // start_at: RUN cycle index on which a stray start is pulsed, -1 for none.
  task automatic run_seq(input int halt_at, input bit halt_level, input int stall_pct,
                         input int stall_w1, input int start_at, input bit abort_w1);
    int rst_len = 0, en_len = 0, dump_len = 0, stalls = 0, nw = 0, w1_stalls = 0;
    int exp_run;
    bit prev_stall = 0, fin = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_timeout_clr", timeout, 0);
    check("start_done_lo", done, 0);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (done) begin
        fin = 1;
      end else begin
        if (!halt_level) halt_seen = 1'b0;
        start = 1'b0;
        if (cpu_reset && busy) rst_len++;
        if (cpu_en) begin
          if (en_len == halt_at) halt_seen = 1'b1;
          if (en_len == start_at) start = 1'b1;
          en_len++;
        end
        if (busy && !cpu_en && !cpu_reset) dump_len++;
        if (dmem_sel) check("dmem_addr", dmem_addr, nw);
        if (prev_stall) begin
          check("hold_valid", dump_valid, 1);
          check("hold_addr", dump_addr, prev_addr);
          check("hold_data", dump_data, prev_data);
        end
        if (dump_valid) begin
          if (abort_w1 && dump_addr == 1) begin
            dump_ready = 1'b0;
            #2 reset = 1'b1;
            #1 check_reset_vals("abort");
            @(posedge clk);
            #1 check_reset_vals("abort_edge");
            @(negedge clk);
            reset = 1'b0;
            halt_seen = 1'b0;
            start = 1'b0;
            @(negedge clk);
            check("abort_idle_busy", busy, 0);
            check("abort_idle_cpu_reset", cpu_reset, 1);
            return;
          end
          if (dump_addr == 1 && w1_stalls < stall_w1) begin
            dump_ready = 1'b0;
            w1_stalls++;
          end else begin
            dump_ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
          end
          if (!dump_ready) begin
            stalls++;
          end else begin
            if (nw < DUMP) begin
              check("word_addr", dump_addr, nw);
              check("word_data", dump_data, mem[nw]);
            end else begin
              check("extra_word", nw, DUMP - 1);
            end
            nw++;
          end
          prev_addr = dump_addr;
          prev_data = dump_data;
        end else begin
          dump_ready = 1'($urandom_range(1));
        end
        prev_stall = dump_valid && !dump_ready;
        @(negedge clk);
      end
    end
    halt_seen  = 1'b0;
    start      = 1'b0;
    dump_ready = 1'b0;
    exp_run = (halt_at < 0) ? MAXC : halt_at + 1;
    check("seq_done", done, 1);
    check("rst_len", rst_len, RSTC);
    check("en_len", en_len, exp_run + DRAIN);
    check("timeout", timeout, (halt_at < 0) ? 1 : 0);
    check("word_count", nw, DUMP);
    check("dump_len", dump_len, 3 * DUMP + stalls);
    check("done_cpu_en", cpu_en, 0);
    check("done_cpu_reset", cpu_reset, 0);
    check("done_busy", busy, 0);
    check("done_dmem_sel", dmem_sel, 0);
    check("done_valid", dump_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h, sa;
    reset = 1'b1; start = 1'b0; halt_seen = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // GCD(48,18) result image, ready always high
    mem[0] = 16'd48; mem[1] = 16'd18; mem[2] = 16'd6;
    run_seq(10, 0, 0, 0, -1, 0);
    // no halt: budget expires
    run_seq(-1, 0, 0, 0, -1, 0);
    // halt on the final budget cycle
    run_seq(MAXC - 1, 1, 0, 0, -1, 0);
    // consumer stalls word 1 for five cycles
    run_seq(7, 0, 0, 5, -1, 0);
    // stray start during RUN
    run_seq(12, 0, 0, 0, 3, 0);
    // reset during OUT of word 1, then a full run from IDLE
    run_seq(5, 0, 0, 0, -1, 1);
    run_seq(5, 0, 0, 0, -1, 0);

    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < DUMP; i++) mem[i] = DW'($urandom);
      h  = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(MAXC - 1));
      sa = ($urandom_range(1) == 1) ? int'($urandom_range(((h < 0) ? MAXC : h + 1) - 1)) : -1;
      run_seq(h, 1'($urandom_range(1)), 40, 0, sa, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
